dm_copy_engine: RTL and testbench

Memory-to-memory block-copy initiator that drives the data-memory word port (address, write data, write enable) and consumes its combinational read data. It sits beside the CPU datapath on the data-memory port, behind the port mux, and moves `len` 32-bit words from `src_addr` to `dst_addr` using one read cycle and one write cycle per word. While `busy` is high the engine owns the memory port and the CPU stalls.

---
 rtl/dm_copy_engine_if.sv | 27 ++
 rtl/dm_copy_engine.sv | 130 +++++++++++++
 tb/tb_dm_copy_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_copy_engine_if.sv
// Control and data-memory port bundle for dm_copy_engine.
// master: the copy engine; slave: the requester/memory side.
interface dm_copy_engine_if #(
    parameter int unsigned LEN_W = 12
);
    logic              start;
    logic [31:0]       src_addr;
    logic [31:0]       dst_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  words_copied;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    modport master (
        input  start, src_addr, dst_addr, len, mem_rdata,
        output busy, done, words_copied, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output start, src_addr, dst_addr, len, mem_rdata,
        input  busy, done, words_copied, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dm_copy_engine.sv
// Memory-to-memory block copy initiator: one read and one write cycle per 32-bit word.
// Optional DM_COPY_OVERLAP_SAFE_EN: forward-overlapping copies run descending (memmove).
module dm_copy_engine #(
    parameter int unsigned LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    dm_copy_engine_if.master bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [AW-1:0]     r_src, r_dst, w_src_nxt, w_dst_nxt;
    logic [LEN_W-1:0]  r_len, r_cnt, w_len_nxt, w_cnt_nxt;
    logic              r_desc, w_desc_nxt;
    logic              r_busy, r_done, r_we, w_busy_nxt, w_done_nxt, w_we_nxt;
    logic [AW-1:0]     r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0]     r_mem_wdata, w_mem_wdata_nxt;

    logic [AW-1:0]     w_src_al, w_dst_al, w_src_start, w_dst_start;
    logic              w_desc_cap;

    assign w_src_al = bus.src_addr & ~AW'(3);
    assign w_dst_al = bus.dst_addr & ~AW'(3);

`ifdef DM_COPY_OVERLAP_SAFE_EN
    // Forward overlap (src < dst < src+4*len) evaluated in 33 bits so the end never wraps.
    logic [AW:0]   w_src_end;
    logic [AW-1:0] w_back_off;
    assign w_src_end   = {1'b0, w_src_al} + ((AW+1)'(bus.len) << 2);
    assign w_desc_cap  = (w_src_al < w_dst_al) && ({1'b0, w_dst_al} < w_src_end);
    assign w_back_off  = (AW'(bus.len) - AW'(1)) << 2;
    assign w_src_start = w_desc_cap ? (w_src_al + w_back_off) : w_src_al;
    assign w_dst_start = w_desc_cap ? (w_dst_al + w_back_off) : w_dst_al;
`else
    assign w_desc_cap  = 1'b0;
    assign w_src_start = w_src_al;
    assign w_dst_start = w_dst_al;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_desc      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_src       <= w_src_nxt;
            r_dst       <= w_dst_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_desc      <= w_desc_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_we        <= w_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_src_nxt       = r_src;
        w_dst_nxt       = r_dst;
        w_len_nxt       = r_len;
        w_cnt_nxt       = r_cnt;
        w_desc_nxt      = r_desc;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_we_nxt        = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_src_nxt   = w_src_start;
                    w_dst_nxt   = w_dst_start;
                    w_len_nxt   = bus.len;
                    w_cnt_nxt   = '0;
                    w_desc_nxt  = w_desc_cap;
                    w_state_nxt = (bus.len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ:  w_state_nxt = S_WRITE;
            S_WRITE: begin
                w_cnt_nxt   = r_cnt + LEN_W'(1);
                w_src_nxt   = r_desc ? (r_src - AW'(4)) : (r_src + AW'(4));
                w_dst_nxt   = r_desc ? (r_dst - AW'(4)) : (r_dst + AW'(4));
                w_state_nxt = (w_cnt_nxt == r_len) ? S_DONE : S_READ;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Registered port outputs reflect the state being entered; the write buffer is mem_wdata itself.
        case (w_state_nxt)
            S_READ: begin
                w_busy_nxt     = 1'b1;
                w_mem_addr_nxt = w_src_nxt;
            end
            S_WRITE: begin
                w_busy_nxt      = 1'b1;
                w_we_nxt        = 1'b1;
                w_mem_addr_nxt  = r_dst;
                w_mem_wdata_nxt = bus.mem_rdata;
            end
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.words_copied = r_cnt;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.mem_we       = r_we;
endmodule

// File: tb/tb_dm_copy_engine.sv
// Bench for dm_copy_engine: 4 KiB aliased word memory, directed scenarios plus random copies
// checked against a sequential word-copy reference model.
module tb_dm_copy_engine;
    localparam int unsigned LW    = 12;
    localparam int unsigned NWORD = 1024;

    logic clk;
    logic rst_n;

    dm_copy_engine_if #(.LEN_W(LW)) bus ();

    dm_copy_engine #(.LEN_W(LW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem      [0:NWORD-1];
    logic [31:0] fill_mem [0:NWORD-1];
    logic [31:0] ref_mem  [0:NWORD-1];
    logic        fill_en;
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];

    int n_cmp = 0;
    int n_bad = 0;
    int wr_total = 0, done_total = 0, consec_viol = 0, bd_viol = 0;
    logic prev_we = 1'b0;

    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

    // Memory and bus monitor.
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < NWORD; i++) mem[i] <= fill_mem[i];
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
        end
        if (bus.mem_we) wr_total++;
        if (bus.mem_we && prev_we) consec_viol++;
        if (bus.done) done_total++;
        if (bus.busy && bus.done) bd_viol++;
        prev_we = bus.mem_we;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: copy word by word in the engine's order on a scratch image, recording each write.
    task automatic model_plan(input logic [31:0] s_raw, input logic [31:0] d_raw, input int l);
        logic [31:0] s, d, a_src, a_dst;
        logic [31:0] scratch [0:NWORD-1];
        bit desc;
        int i;
        s = s_raw & ~32'h3;
        d = d_raw & ~32'h3;
        exp_addr.delete();
        exp_data.delete();
        scratch = ref_mem;
        desc = 1'b0;
`ifdef DM_COPY_OVERLAP_SAFE_EN
        desc = (longint'(s) < longint'(d)) && (longint'(d) < longint'(s) + 4 * longint'(l));
`endif
        for (int k = 0; k < l; k++) begin
            i = desc ? (l - 1 - k) : k;
            a_src = s + 32'(4 * i);
            a_dst = d + 32'(4 * i);
            exp_addr.push_back(a_dst);
            exp_data.push_back(scratch[a_src[11:2]]);
            scratch[a_dst[11:2]] = scratch[a_src[11:2]];
        end
    endtask

    task automatic model_commit(input int n);
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            a = exp_addr[k];
            ref_mem[a[11:2]] = exp_data[k];
        end
    endtask

    function automatic int count_diffs();
        int n = 0;
        for (int i = 0; i < NWORD; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic do_fill();
        for (int i = 0; i < NWORD; i++) ref_mem[i] = fill_mem[i];
        fill_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fill_en = 1'b0;
    endtask

    task automatic random_fill();
        for (int i = 0; i < NWORD; i++) fill_mem[i] = $urandom;
    endtask

    // Entered just before the start edge (edge 0); cycle n is sampled at the negedge after edge n-1.
    task automatic wait_copy(input logic [31:0] s, input logic [31:0] d, input int l, input bit inject);
        int  base_wr, nwr;
        bit  seen;
        logic [31:0] ea;
        model_plan(s, d, l);
        base_wr = wr_total;
        nwr     = 0;
        seen    = 1'b0;
        for (int cyc = 1; cyc <= 2 * l + 16 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.start = 1'b0;
            if (inject && cyc == 3) begin
                bus.start = 1'b1; bus.src_addr = 32'h200; bus.dst_addr = 32'h300; bus.len = LW'(1);
            end
            if (inject && cyc == 4) bus.start = 1'b0;
            if (bus.mem_we) begin
                if (nwr < exp_addr.size()) begin
                    ea = exp_addr[nwr];
                    check_val("wr_cycle", 64'(cyc), 64'(2 * nwr + 2));
                    check_val("wr_addr", 64'(bus.mem_addr), 64'(ea));
                    check_val("wr_data", 64'(bus.mem_wdata), 64'(exp_data[nwr]));
                end
                nwr++;
            end
            if (bus.done) begin
                seen = 1'b1;
                check_val("done_cycle", 64'(cyc), 64'(2 * l + 1));
                check_val("words_copied", 64'(bus.words_copied), 64'(l));
                check_val("busy_at_done", 64'(bus.busy), 64'(0));
            end
        end
        if (!seen) check_val("done_timeout", 64'(0), 64'(1));
        check_val("write_count", 64'(wr_total - base_wr), 64'(l));
        model_commit(l);
        check_val("mem_image", 64'(count_diffs()), 64'(0));
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int l, input bit inject);
        @(negedge clk);
        check_val("idle_done", 64'(bus.done), 64'(0));
        check_val("idle_busy", 64'(bus.busy), 64'(0));
        bus.start    = 1'b1;
        bus.src_addr = s;
        bus.dst_addr = d;
        bus.len      = LW'(l);
        wait_copy(s, d, l, inject);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_wr, base_done, l;
        logic [31:0] s, d;

        rst_n = 1'b0;
        fill_en = 1'b0;
        bus.start = 1'b1;
        bus.src_addr = 32'h0;
        bus.dst_addr = 32'h100;
        bus.len = LW'(4);

        // Reset held with start asserted, then released into the basic copy.
        random_fill();
        fill_mem[0] = 32'h11; fill_mem[1] = 32'h22; fill_mem[2] = 32'h33; fill_mem[3] = 32'h44;
        do_fill();
        repeat (2) @(negedge clk);
        check_val("rst_busy", 64'(bus.busy), 64'(0));
        check_val("rst_done", 64'(bus.done), 64'(0));
        check_val("rst_words", 64'(bus.words_copied), 64'(0));
        check_val("rst_addr", 64'(bus.mem_addr), 64'(0));
        check_val("rst_wdata", 64'(bus.mem_wdata), 64'(0));
        check_val("rst_we", 64'(bus.mem_we), 64'(0));
        rst_n = 1'b1;
        wait_copy(32'h0, 32'h100, 4, 1'b0);
        check_val("basic_w0", 64'(mem[64]), 64'h11);
        check_val("basic_w3", 64'(mem[67]), 64'h44);

        // Zero length.
        run_copy(32'h40, 32'h80, 0, 1'b0);
        check_val("zero_words", 64'(bus.words_copied), 64'(0));

        // Start during a busy copy is ignored; next copy begins the cycle after done.
        run_copy(32'h0, 32'h100, 4, 1'b1);
        run_copy(32'h10, 32'h200, 4, 1'b0);

        // Forward-overlapping copy.
        random_fill();
        fill_mem[0] = 32'hA; fill_mem[1] = 32'hB; fill_mem[2] = 32'hC; fill_mem[3] = 32'hD;
        do_fill();
        run_copy(32'h0, 32'h4, 3, 1'b0);
        check_val("ovl_w1", 64'(mem[1]), 64'hA);
`ifdef DM_COPY_OVERLAP_SAFE_EN
        check_val("ovl_w2", 64'(mem[2]), 64'hB);
        check_val("ovl_w3", 64'(mem[3]), 64'hC);
`else
        check_val("ovl_w2", 64'(mem[2]), 64'hA);
        check_val("ovl_w3", 64'(mem[3]), 64'hA);
`endif

        // Address wrap past 0xFFFFFFFC, unaligned inputs.
        run_copy(32'hFFFF_FFF9, 32'h0000_0402, 4, 1'b0);
        run_copy(32'h0000_0803, 32'hFFFF_FFF4, 5, 1'b0);

        // Mid-copy reset during the read of word 2.
        @(negedge clk);
        bus.start = 1'b1; bus.src_addr = 32'h20; bus.dst_addr = 32'h300; bus.len = LW'(4);
        model_plan(32'h20, 32'h300, 4);
        base_wr = wr_total;
        base_done = done_total;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mrst_we", 64'(bus.mem_we), 64'(0));
        check_val("mrst_busy", 64'(bus.busy), 64'(0));
        check_val("mrst_addr", 64'(bus.mem_addr), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("mrst_idle", 64'(bus.busy), 64'(0));
        check_val("mrst_writes", 64'(wr_total - base_wr), 64'(2));
        check_val("mrst_no_done", 64'(done_total - base_done), 64'(0));
        model_commit(2);
        check_val("mrst_mem", 64'(count_diffs()), 64'(0));

        // Random copies, including near-overlaps in both directions.
        random_fill();
        do_fill();
        for (int t = 0; t < 30; t++) begin
            l = int'($urandom_range(0, 12));
            s = 32'($urandom_range(0, NWORD - 1)) * 32'd4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                d = s + 32'd4 * 32'($urandom_range(0, 12)) - 32'd24 + 32'($urandom_range(0, 3));
            else
                d = $urandom;
            run_copy(s, d, l, 1'b0);
        end

        check_val("we_consecutive", 64'(consec_viol), 64'(0));
        check_val("busy_and_done", 64'(bd_viol), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
